// File: rtl/eth_udp_rx_parser.sv
// Ethernet/IPv4/UDP receive parser: filters frames on MAC/IP/port, captures header
// metadata and realigns the UDP payload (which starts mid-word) onto 32-bit beats.
module eth_udp_rx_parser #(
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0102,
  parameter logic [15:0] LOCAL_PORT = 16'd1234
) (
  input  logic        aclk,
  input  logic        rst,
  input  logic [31:0] eth_rxd_tdata,
  input  logic [3:0]  eth_rxd_tkeep,
  input  logic        eth_rxd_tlast,
  input  logic        eth_rxd_tvalid,
  output logic        eth_rxd_tready,
  output logic [31:0] data_tdata,
  output logic [3:0]  data_tkeep,
  output logic        data_tlast,
  output logic        data_tvalid,
  input  logic        data_tready,
  output logic [31:0] meta_src_ip,
  output logic [15:0] meta_src_port,
  output logic [15:0] meta_udp_len,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {HDR, PASS, TAIL, DROP} state_t;

  state_t      r_state, w_state_n;
  logic [3:0]  r_wcnt, w_wcnt_n;
  logic [15:0] r_res, w_res_n;
  logic        r_tail_two, w_tail_two_n;
  logic [31:0] r_cap_ip;
  logic [15:0] r_cap_port, r_cap_len;
  logic [31:0] r_odata, w_odata;
  logic [3:0]  r_okeep, w_okeep;
  logic        r_olast, w_olast, r_ovld;
  logic [31:0] r_meta_ip;
  logic [15:0] r_meta_port, r_meta_len, r_drop;
  logic        w_tready, w_load, w_res_ld, w_drop, w_commit, w_out_free, w_acc;

  function automatic logic hdr_ok(input logic [3:0] idx, input logic [31:0] d);
    case (idx)
      4'd0:    hdr_ok = (d == LOCAL_MAC[47:16]);
      4'd1:    hdr_ok = (d[31:16] == LOCAL_MAC[15:0]);
      4'd3:    hdr_ok = (d[31:16] == 16'h0800) && (d[15:8] == 8'h45);
      4'd5:    hdr_ok = (d[7:0] == 8'd17);
      4'd7:    hdr_ok = (d[15:0] == LOCAL_IP[31:16]);
      4'd8:    hdr_ok = (d[31:16] == LOCAL_IP[15:0]);
      4'd9:    hdr_ok = (d[31:16] == LOCAL_PORT);
      default: hdr_ok = 1'b1;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_out_free = !r_ovld || data_tready;
  assign w_acc      = eth_rxd_tvalid && w_tready;

  always_comb begin
    w_state_n    = r_state;
    w_wcnt_n     = r_wcnt;
    w_tready     = 1'b0;
    w_load       = 1'b0;
    w_odata      = 32'h0;
    w_okeep      = 4'h0;
    w_olast      = 1'b0;
    w_res_ld     = 1'b0;
    w_res_n      = r_res;
    w_tail_two_n = r_tail_two;
    w_drop       = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      HDR: begin
        // Word 10 may emit a one-beat frame, so it waits for a free output slot
        // rather than overwrite a beat the sink has not yet taken.
        w_tready = (r_wcnt != 4'd10) || w_out_free;
        if (eth_rxd_tvalid && w_tready) begin
          w_wcnt_n = r_wcnt + 4'd1;
          if (r_wcnt != 4'd10) begin
            if (!hdr_ok(r_wcnt, eth_rxd_tdata)) begin
              w_drop    = 1'b1;
              w_wcnt_n  = 4'd0;
              w_state_n = eth_rxd_tlast ? HDR : DROP;
            end else if (eth_rxd_tlast) begin
              w_drop   = 1'b1;
              w_wcnt_n = 4'd0;
            end
          end else begin
            w_wcnt_n = 4'd0;
            if (eth_rxd_tlast && !eth_rxd_tkeep[1]) begin
              w_drop = 1'b1;
            end else begin
              w_commit = 1'b1;
              if (eth_rxd_tlast) begin
                w_load  = 1'b1;
                w_olast = 1'b1;
                if (eth_rxd_tkeep[0]) begin
                  w_odata = {eth_rxd_tdata[15:0], 16'h0};
                  w_okeep = 4'b1100;
                end else begin
                  w_odata = {eth_rxd_tdata[15:8], 24'h0};
                  w_okeep = 4'b1000;
                end
              end else begin
                w_res_ld  = 1'b1;
                w_res_n   = eth_rxd_tdata[15:0];
                w_state_n = PASS;
              end
            end
          end
        end
      end
      PASS: begin
        w_tready = w_out_free;
        if (eth_rxd_tvalid && w_tready) begin
          w_load   = 1'b1;
          w_res_ld = 1'b1;
          w_res_n  = eth_rxd_tdata[15:0];
          w_odata  = {r_res, eth_rxd_tdata[31:16]};
          w_okeep  = 4'b1111;
          if (eth_rxd_tlast) begin
            case (eth_rxd_tkeep)
              4'b1000: begin
                w_odata   = {r_res, eth_rxd_tdata[31:24], 8'h0};
                w_okeep   = 4'b1110;
                w_olast   = 1'b1;
                w_state_n = HDR;
              end
              4'b1100: begin
                w_olast   = 1'b1;
                w_state_n = HDR;
              end
              4'b1110: begin
                w_res_n      = {eth_rxd_tdata[15:8], 8'h0};
                w_tail_two_n = 1'b0;
                w_state_n    = TAIL;
              end
              default: begin
                w_tail_two_n = 1'b1;
                w_state_n    = TAIL;
              end
            endcase
          end
        end
      end
      TAIL: begin
        if (w_out_free) begin
          w_load    = 1'b1;
          w_olast   = 1'b1;
          w_odata   = r_tail_two ? {r_res, 16'h0} : {r_res[15:8], 24'h0};
          w_okeep   = r_tail_two ? 4'b1100 : 4'b1000;
          w_state_n = HDR;
        end
      end
      DROP: begin
        w_tready = 1'b1;
        if (eth_rxd_tvalid && eth_rxd_tlast) w_state_n = HDR;
      end
    endcase
  end

  // Header fields are staged here and only published once the frame is accepted.
  always_ff @(posedge aclk) begin
    if (r_state == HDR && w_acc) begin
      case (r_wcnt)
        4'd6:    r_cap_ip[31:16] <= eth_rxd_tdata[15:0];
        4'd7:    r_cap_ip[15:0]  <= eth_rxd_tdata[31:16];
        4'd8:    r_cap_port      <= eth_rxd_tdata[15:0];
        4'd9:    r_cap_len       <= eth_rxd_tdata[15:0];
        default: ;
      endcase
    end
  end

  // Single registered output stage.
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state     <= HDR;
      r_wcnt      <= 4'd0;
      r_res       <= 16'h0;
      r_tail_two  <= 1'b0;
      r_odata     <= 32'h0;
      r_okeep     <= 4'h0;
      r_olast     <= 1'b0;
      r_ovld      <= 1'b0;
      r_meta_ip   <= 32'h0;
      r_meta_port <= 16'h0;
      r_meta_len  <= 16'h0;
      r_drop      <= 16'h0;
    end else begin
      r_state    <= w_state_n;
      r_wcnt     <= w_wcnt_n;
      r_tail_two <= w_tail_two_n;
      if (w_res_ld) r_res <= w_res_n;
      if (w_load) begin
        r_odata <= w_odata;
        r_okeep <= w_okeep;
        r_olast <= w_olast;
        r_ovld  <= 1'b1;
      end else if (data_tready) begin
        r_ovld <= 1'b0;
      end
      if (w_commit) begin
        r_meta_ip   <= r_cap_ip;
        r_meta_port <= r_cap_port;
        r_meta_len  <= r_cap_len;
      end
      if (w_drop) r_drop <= sat_inc(r_drop);
    end
  end

  assign eth_rxd_tready = w_tready;
  assign data_tdata     = r_odata;
  assign data_tkeep     = r_okeep;
  assign data_tlast     = r_olast;
  assign data_tvalid    = r_ovld;
  assign meta_src_ip    = r_meta_ip;
  assign meta_src_port  = r_meta_port;
  assign meta_udp_len   = r_meta_len;
  assign drop_count     = r_drop;

endmodule

// File: tb/tb_eth_udp_rx_parser.sv
// Directed bench for eth_udp_rx_parser: builds frames byte by byte and checks the
// realigned payload, metadata and drop counter against hand-derived values.
module tb_eth_udp_rx_parser;
  logic        aclk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] eth_rxd_tdata = 32'h0;
  logic [3:0]  eth_rxd_tkeep = 4'h0;
  logic        eth_rxd_tlast = 1'b0;
  logic        eth_rxd_tvalid = 1'b0;
  logic        eth_rxd_tready;
  logic [31:0] data_tdata;
  logic [3:0]  data_tkeep;
  logic        data_tlast;
  logic        data_tvalid;
  logic        data_tready = 1'b1;
  logic [31:0] meta_src_ip;
  logic [15:0] meta_src_port;
  logic [15:0] meta_udp_len;
  logic [15:0] drop_count;

  eth_udp_rx_parser dut (
    .aclk(aclk), .rst(rst),
    .eth_rxd_tdata(eth_rxd_tdata), .eth_rxd_tkeep(eth_rxd_tkeep),
    .eth_rxd_tlast(eth_rxd_tlast), .eth_rxd_tvalid(eth_rxd_tvalid),
    .eth_rxd_tready(eth_rxd_tready),
    .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .meta_src_ip(meta_src_ip), .meta_src_port(meta_src_port),
    .meta_udp_len(meta_udp_len), .drop_count(drop_count)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int hold_viol = 0;
  logic [7:0]  fb[$];
  logic [7:0]  ob[$];
  logic [31:0] obd[$];
  logic [3:0]  obk[$];
  logic        obl[$];
  logic        m_pv = 1'b0, m_pr = 1'b0, m_pl = 1'b0;
  logic [31:0] m_pd = 32'h0;
  logic [3:0]  m_pk = 4'h0;

  // Output monitor: collects accepted beats and flags any change while stalled.
  always @(negedge aclk) begin
    if (!rst) begin
      if (m_pv && !m_pr && (data_tvalid !== 1'b1 || data_tdata !== m_pd ||
                            data_tkeep !== m_pk || data_tlast !== m_pl))
        hold_viol++;
      if (data_tvalid === 1'b1 && data_tready === 1'b1) begin
        obd.push_back(data_tdata);
        obk.push_back(data_tkeep);
        obl.push_back(data_tlast);
        for (int b = 0; b < 4; b++)
          if (data_tkeep[3-b]) ob.push_back(data_tdata[31-8*b -: 8]);
      end
    end
    m_pv = data_tvalid && !rst;
    m_pr = data_tready;
    m_pd = data_tdata;
    m_pk = data_tkeep;
    m_pl = data_tlast;
  end

  task automatic build_frame(input logic [47:0] mac, input logic [7:0] proto,
                             input logic [31:0] sip, input logic [15:0] sport,
                             input int plen, input logic [7:0] pstart);
    logic [15:0] tl;
    logic [15:0] ul;
    logic [7:0]  pb;
    tl = 16'(28 + plen);
    ul = 16'(8 + plen);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(mac[47-8*i -: 8]);
    fb.push_back(8'h02); for (int i = 0; i < 4; i++) fb.push_back(8'h00); fb.push_back(8'hAA);
    fb.push_back(8'h08); fb.push_back(8'h00);
    fb.push_back(8'h45); fb.push_back(8'h00); fb.push_back(tl[15:8]); fb.push_back(tl[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h40); fb.push_back(8'h00);
    fb.push_back(8'h40); fb.push_back(proto); fb.push_back(8'h00); fb.push_back(8'h00);
    for (int i = 0; i < 4; i++) fb.push_back(sip[31-8*i -: 8]);
    fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h01); fb.push_back(8'h02);
    fb.push_back(sport[15:8]); fb.push_back(sport[7:0]);
    fb.push_back(8'h04); fb.push_back(8'hD2);
    fb.push_back(ul[15:8]); fb.push_back(ul[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h00);
    pb = pstart;
    for (int i = 0; i < plen; i++) begin fb.push_back(pb); pb = pb + 8'd1; end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    eth_rxd_tdata = d; eth_rxd_tkeep = k; eth_rxd_tlast = l; eth_rxd_tvalid = 1'b1;
    @(negedge aclk);
    while (eth_rxd_tready !== 1'b1 && n < 200) begin
      n++; stall_cnt++;
      @(negedge aclk);
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drive_timeout: tready stayed %b, want 1", eth_rxd_tready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic send_frame(input int max_beats, input bit force_last);
    int nb, nfull, nw, idx;
    logic [31:0] d;
    logic [3:0]  k;
    nb = fb.size();
    nfull = (nb + 3) / 4;
    nw = (max_beats < nfull) ? max_beats : nfull;
    for (int w = 0; w < nw; w++) begin
      d = 32'h0; k = 4'h0;
      for (int b = 0; b < 4; b++) begin
        idx = w * 4 + b;
        if (idx < nb) begin d[31-8*b -: 8] = fb[idx]; k[3-b] = 1'b1; end
      end
      drive_beat(d, k, (w == nw - 1) && (force_last || nw == nfull));
    end
    eth_rxd_tvalid = 1'b0; eth_rxd_tlast = 1'b0; eth_rxd_tdata = 32'h0; eth_rxd_tkeep = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge aclk);
    #1 rst = 1'b0;
    @(negedge aclk);
    checks++; if (data_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", data_tvalid); end
    checks++; if (data_tdata !== 32'h0) begin errors++; $display("FAIL rst_tdata: got %h want 0", data_tdata); end
    checks++; if (eth_rxd_tready !== 1'b1) begin errors++; $display("FAIL rst_tready: got %b want 1", eth_rxd_tready); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL rst_drop: got %0d want 0", drop_count); end
    checks++; if (meta_src_ip !== 32'h0 || meta_udp_len !== 16'h0) begin
      errors++; $display("FAIL rst_meta: got %h/%h want 0/0", meta_src_ip, meta_udp_len); end
    @(posedge aclk); #1;
  endtask

  task automatic test_pass16();
    int bb, kb, bad;
    bb = ob.size(); kb = obd.size(); bad = 0;
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 16, 8'h00);
    send_frame(100, 1'b0);
    repeat (6) @(posedge aclk); #1;
    checks++; if (obd.size() - kb != 4) begin errors++; $display("FAIL p16_beats: got %0d want 4", obd.size() - kb); end
    checks++; if (obd.size() < kb + 1 || obd[kb] !== 32'h00010203) begin
      errors++; $display("FAIL p16_first: got %h want 00010203", (obd.size() > kb) ? obd[kb] : 32'hX); end
    checks++; if (obd.size() < kb + 4 || obd[kb+3] !== 32'h0C0D0E0F || obk[kb+3] !== 4'b1111 || obl[kb+3] !== 1'b1) begin
      errors++; $display("FAIL p16_last: got beat count %0d, want 0C0D0E0F/1111/last", obd.size() - kb); end
    if (ob.size() - bb != 16) bad = 1;
    else for (int i = 0; i < 16; i++) if (ob[bb+i] !== 8'(i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL p16_bytes: got %0d bytes (%0d bad) want 16", ob.size() - bb, bad); end
    checks++; if (meta_udp_len !== 16'd24) begin errors++; $display("FAIL p16_len: got %0d want 24", meta_udp_len); end
    checks++; if (meta_src_ip !== 32'hC0A8010A || meta_src_port !== 16'h1388) begin
      errors++; $display("FAIL p16_meta: got %h/%h want C0A8010A/1388", meta_src_ip, meta_src_port); end
    checks++; if (drop_count !== 16'h0) begin errors++; $display("FAIL p16_drop: got %0d want 0", drop_count); end
  endtask

  task automatic test_tail();
    int kb;
    kb = obd.size();
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 17, 8'h00);
    send_frame(100, 1'b0);
    @(negedge aclk);
    checks++; if (eth_rxd_tready !== 1'b0) begin errors++; $display("FAIL tail_tready: got %b want 0", eth_rxd_tready); end
    @(posedge aclk); #1;
    repeat (5) @(posedge aclk); #1;
    checks++; if (obd.size() - kb != 5) begin errors++; $display("FAIL t17_beats: got %0d want 5", obd.size() - kb); end
    checks++; if (obd.size() < kb + 5 || obd[kb+4] !== 32'h10000000 || obk[kb+4] !== 4'b1000 || obl[kb+4] !== 1'b1 || obl[kb+3] !== 1'b0) begin
      errors++; $display("FAIL t17_tail: got %h want 10000000/1000/last", (obd.size() >= kb + 5) ? obd[kb+4] : 32'hX); end
    kb = obd.size();
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 18, 8'h00);
    send_frame(100, 1'b0);
    repeat (6) @(posedge aclk); #1;
    checks++; if (obd.size() < kb + 5 || obd[kb+4] !== 32'h10110000 || obk[kb+4] !== 4'b1100 || obl[kb+4] !== 1'b1) begin
      errors++; $display("FAIL t18_tail: got %h want 10110000/1100/last", (obd.size() >= kb + 5) ? obd[kb+4] : 32'hX); end
  endtask

  task automatic test_bad_mac();
    int bb, kb, s0, bad;
    kb = obd.size(); s0 = stall_cnt;
    build_frame(48'h02_00_00_00_00_01, 8'd17, 32'hC0A8010A, 16'h1388, 16, 8'h00);
    send_frame(100, 1'b0);
    repeat (4) @(posedge aclk); #1;
    checks++; if (obd.size() != kb) begin errors++; $display("FAIL mac_out: got %0d beats want 0", obd.size() - kb); end
    checks++; if (stall_cnt != s0) begin errors++; $display("FAIL mac_tready: got %0d stalls want 0", stall_cnt - s0); end
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL mac_drop: got %0d want 1", drop_count); end
    bb = ob.size(); bad = 0;
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 8, 8'h40);
    send_frame(100, 1'b0);
    repeat (5) @(posedge aclk); #1;
    if (ob.size() - bb != 8) bad = 1;
    else for (int i = 0; i < 8; i++) if (ob[bb+i] !== 8'(8'h40 + i)) bad++;
    checks++; if (bad != 0 || drop_count !== 16'd1) begin
      errors++; $display("FAIL mac_next: got %0d bytes (%0d bad) drop %0d want 8/0/1", ob.size() - bb, bad, drop_count); end
  endtask

  task automatic test_bad_proto();
    int kb;
    rst = 1'b1; @(posedge aclk); #1 rst = 1'b0;
    kb = obd.size();
    build_frame(48'h02_00_00_00_00_00, 8'd6, 32'hC0A8010A, 16'h1388, 16, 8'h00);
    send_frame(100, 1'b0);
    repeat (3) @(posedge aclk); #1;
    checks++; if (drop_count !== 16'd1) begin errors++; $display("FAIL tcp_drop: got %0d want 1", drop_count); end
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 16, 8'h00);
    send_frame(5, 1'b1);
    repeat (3) @(posedge aclk); #1;
    checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL trunc_drop: got %0d want 2", drop_count); end
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 0, 8'h00);
    send_frame(100, 1'b0);
    repeat (3) @(posedge aclk); #1;
    checks++; if (drop_count !== 16'd3) begin errors++; $display("FAIL zero_drop: got %0d want 3", drop_count); end
    checks++; if (obd.size() != kb) begin errors++; $display("FAIL drop_out: got %0d beats want 0", obd.size() - kb); end
    checks++; if (meta_src_ip !== 32'h0 || meta_udp_len !== 16'h0) begin
      errors++; $display("FAIL drop_meta: got %h/%h want 0/0", meta_src_ip, meta_udp_len); end
  endtask

  task automatic test_short();
    int kb;
    kb = obd.size();
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 1, 8'h77);
    send_frame(100, 1'b0);
    repeat (3) @(posedge aclk); #1;
    checks++; if (obd.size() != kb + 1 || obd[kb] !== 32'h77000000 || obk[kb] !== 4'b1000 || obl[kb] !== 1'b1) begin
      errors++; $display("FAIL short1: got %0d beats, want 77000000/1000/last", obd.size() - kb); end
    kb = obd.size();
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 2, 8'h88);
    send_frame(100, 1'b0);
    repeat (3) @(posedge aclk); #1;
    checks++; if (obd.size() != kb + 1 || obd[kb] !== 32'h88890000 || obk[kb] !== 4'b1100 || obl[kb] !== 1'b1) begin
      errors++; $display("FAIL short2: got %0d beats, want 88890000/1100/last", obd.size() - kb); end
    checks++; if (meta_udp_len !== 16'd10) begin errors++; $display("FAIL short_len: got %0d want 10", meta_udp_len); end
  endtask

  task automatic test_backpressure();
    int bb, kb, hv0, bad;
    bit done;
    bb = ob.size(); kb = obd.size(); hv0 = hold_viol; bad = 0; done = 1'b0;
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 64, 8'h80);
    fork
      begin send_frame(100, 1'b0); done = 1'b1; end
      begin
        while (!done) begin @(posedge aclk); #1 data_tready = ~data_tready; end
      end
    join
    data_tready = 1'b1;
    repeat (5) @(posedge aclk); #1;
    if (ob.size() - bb != 64) bad = 1;
    else for (int i = 0; i < 64; i++) if (ob[bb+i] !== 8'(8'h80 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_bytes: got %0d bytes (%0d bad) want 64", ob.size() - bb, bad); end
    checks++; if (obd.size() - kb != 16 || obl[obd.size()-1] !== 1'b1) begin
      errors++; $display("FAIL bp_beats: got %0d want 16 ending in tlast", obd.size() - kb); end
    checks++; if (hold_viol != hv0) begin errors++; $display("FAIL bp_hold: got %0d changes while stalled want 0", hold_viol - hv0); end
  endtask

  task automatic test_reset_mid();
    int bb, bad;
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A8010A, 16'h1388, 16, 8'h00);
    send_frame(13, 1'b0);
    eth_rxd_tdata = 32'h08090A0B; eth_rxd_tkeep = 4'hF; eth_rxd_tvalid = 1'b1;
    rst = 1'b1;
    @(posedge aclk); #1;
    rst = 1'b0; eth_rxd_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (data_tvalid !== 1'b0 || data_tkeep !== 4'h0 || data_tlast !== 1'b0) begin
      errors++; $display("FAIL rmid_out: got v%b k%h l%b want 0/0/0", data_tvalid, data_tkeep, data_tlast); end
    checks++; if (eth_rxd_tready !== 1'b1 || drop_count !== 16'h0) begin
      errors++; $display("FAIL rmid_state: got tready %b drop %0d want 1/0", eth_rxd_tready, drop_count); end
    @(posedge aclk); #1;
    bb = ob.size(); bad = 0;
    build_frame(48'h02_00_00_00_00_00, 8'd17, 32'hC0A80155, 16'h2222, 4, 8'hA0);
    send_frame(100, 1'b0);
    repeat (4) @(posedge aclk); #1;
    if (ob.size() - bb != 4) bad = 1;
    else for (int i = 0; i < 4; i++) if (ob[bb+i] !== 8'(8'hA0 + i)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_bytes: got %0d bytes (%0d bad) want 4", ob.size() - bb, bad); end
    checks++; if (meta_src_ip !== 32'hC0A80155 || meta_src_port !== 16'h2222 || meta_udp_len !== 16'd12) begin
      errors++; $display("FAIL rmid_meta: got %h/%h/%0d want C0A80155/2222/12", meta_src_ip, meta_src_port, meta_udp_len); end
  endtask

  initial begin
    test_reset();
    test_pass16();
    test_tail();
    test_bad_mac();
    test_bad_proto();
    test_short();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
